// File: rtl/param_sipo_deser_if.sv
// Handshake bundle for param_sipo_deser: serial receive side plus
// the parallel valid/ready word port and status flags.
interface param_sipo_deser_if #(
    parameter int WIDTH = 8
);
    logic             sin_valid;
    logic             sin_data;
    logic             sin_start;
    logic [WIDTH-1:0] dout;
    logic             dout_valid;
    logic             dout_ready;
    logic             frame_err;
    logic             overrun;

    // Deserializer side
    modport slave (
        input  sin_valid, sin_data, sin_start, dout_ready,
        output dout, dout_valid, frame_err, overrun
    );

    // Source / consumer side
    modport master (
        output sin_valid, sin_data, sin_start, dout_ready,
        input  dout, dout_valid, frame_err, overrun
    );
endinterface

// File: rtl/param_sipo_deser.sv
// Serial-in / parallel-out deserializer with resync, frame-error pulse
// and sticky overrun for words dropped under backpressure.
//
//  state | meaning
//  IDLE  | count=0, waiting for bit 0 of a word (sin_start accepted silently)
//  SHIFT | 1..WIDTH-1 bits of the current word received
module param_sipo_deser #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst,
    param_sipo_deser_if.slave    bus
);
    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic [WIDTH-1:0] dout_q, dout_d;
    logic             dout_valid_q, dout_valid_d;
    logic             frame_err_q, frame_err_d;
    logic             overrun_q, overrun_d;

    logic             resync;
    logic [WIDTH-1:0] shift_base;
    logic [WIDTH-1:0] shift_new;
    logic [CW-1:0]    cnt_new;

    // Next-state: shift in qualified bits, complete words, output handshake
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        shift_d      = shift_q;
        dout_d       = dout_q;
        dout_valid_d = dout_valid_q;
        frame_err_d  = 1'b0;
        overrun_d    = overrun_q;

        // A start marker mid-word throws away the partial word
        resync     = bus.sin_valid && bus.sin_start && (state_q == SHIFT);
        shift_base = resync ? '0 : shift_q;
        cnt_new    = (resync ? '0 : cnt_q) + CW'(1);
        if (MSB_FIRST)
            shift_new = {shift_base[WIDTH-2:0], bus.sin_data};
        else
            shift_new = {bus.sin_data, shift_base[WIDTH-1:1]};

        if (dout_valid_q && bus.dout_ready)
            dout_valid_d = 1'b0;

        if (bus.sin_valid) begin
            frame_err_d = resync;
            if (cnt_new == LAST_CNT) begin
                state_d = IDLE;
                cnt_d   = '0;
                shift_d = '0;
                // Slot is free if empty or being consumed at this same edge
                if (!dout_valid_q || bus.dout_ready) begin
                    dout_d       = shift_new;
                    dout_valid_d = 1'b1;
                end else begin
                    overrun_d = 1'b1;
                end
            end else begin
                state_d = SHIFT;
                cnt_d   = cnt_new;
                shift_d = shift_new;
            end
        end
    end

    // State and output registers, synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            shift_q      <= '0;
            dout_q       <= '0;
            dout_valid_q <= 1'b0;
            frame_err_q  <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            shift_q      <= shift_d;
            dout_q       <= dout_d;
            dout_valid_q <= dout_valid_d;
            frame_err_q  <= frame_err_d;
            overrun_q    <= overrun_d;
        end
    end

    assign bus.dout       = dout_q;
    assign bus.dout_valid = dout_valid_q;
    assign bus.frame_err  = frame_err_q;
    assign bus.overrun    = overrun_q;
endmodule

// File: tb/tb_param_sipo_deser.sv
// Directed bench for param_sipo_deser: one MSB-first and one LSB-first
// instance fed the same serial stream and the same dout_ready.
module tb_param_sipo_deser;
    logic clk;
    logic rst;
    int   n_chk;
    int   n_pass;

    param_sipo_deser_if #(.WIDTH(8)) bus0 ();
    param_sipo_deser_if #(.WIDTH(8)) bus1 ();

    param_sipo_deser #(.WIDTH(8), .MSB_FIRST(1'b1)) dut_msb (
        .clk (clk),
        .rst (rst),
        .bus (bus0.slave)
    );

    param_sipo_deser #(.WIDTH(8), .MSB_FIRST(1'b0)) dut_lsb (
        .clk (clk),
        .rst (rst),
        .bus (bus1.slave)
    );

    assign bus1.sin_valid  = bus0.sin_valid;
    assign bus1.sin_data   = bus0.sin_data;
    assign bus1.sin_start  = bus0.sin_start;
    assign bus1.dout_ready = bus0.dout_ready;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    endtask

    task automatic send_bit(input logic d, input logic s);
        @(negedge clk);
        bus0.sin_valid = 1'b1;
        bus0.sin_data  = d;
        bus0.sin_start = s;
    endtask

    task automatic idle();
        @(negedge clk);
        bus0.sin_valid = 1'b0;
        bus0.sin_data  = 1'b0;
        bus0.sin_start = 1'b0;
    endtask

    // Word sent MSB-first in time, start marker on the first bit
    task automatic send_word(input logic [7:0] w);
        for (int i = 7; i >= 0; i--) send_bit(w[i], i == 7);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        repeat (2) begin
            bus0.sin_valid = 1'($urandom);
            bus0.sin_data  = 1'($urandom);
            bus0.sin_start = 1'($urandom);
            @(negedge clk);
        end
        rst            = 1'b0;
        bus0.sin_valid = 1'b0;
        bus0.sin_data  = 1'b0;
        bus0.sin_start = 1'b0;
    endtask

    initial begin
        logic [7:0] w;
        n_chk = 0;
        n_pass = 0;
        rst = 1'b1;
        bus0.sin_valid  = 1'b0;
        bus0.sin_data   = 1'b0;
        bus0.sin_start  = 1'b0;
        bus0.dout_ready = 1'b1;

        // Reset, then a word immediately after
        do_reset();
        chk("rst_dout",       32'(bus0.dout), 32'h00);
        chk("rst_dout_valid", 32'(bus0.dout_valid), 0);
        chk("rst_frame_err",  32'(bus0.frame_err), 0);
        chk("rst_overrun",    32'(bus0.overrun), 0);
        send_word(8'h5A);
        idle();
        chk("post_rst_dout",  32'(bus0.dout), 32'h5A);
        chk("post_rst_valid", 32'(bus0.dout_valid), 1);

        // Basic word A5: valid for exactly one cycle
        idle();
        chk("valid_one_cycle", 32'(bus0.dout_valid), 0);
        send_bit(1'b1, 1'b1);
        send_bit(1'b0, 1'b0);
        chk("start_in_idle_no_ferr", 32'(bus0.frame_err), 0);
        for (int i = 5; i >= 0; i--) send_bit(w_a5(i), 1'b0);
        idle();
        chk("a5_msb_dout",  32'(bus0.dout), 32'hA5);
        chk("a5_msb_valid", 32'(bus0.dout_valid), 1);
        chk("a5_lsb_dout",  32'(bus1.dout), 32'hA5);
        idle();
        chk("a5_valid_drop", 32'(bus0.dout_valid), 0);

        // 0x01: MSB-first gives 0x01, LSB-first gives 0x80
        send_word(8'h01);
        idle();
        chk("x01_msb_dout", 32'(bus0.dout), 32'h01);
        chk("x01_lsb_dout", 32'(bus1.dout), 32'h80);
        idle();

        // Gapped 0x3C
        w = 8'h3C;
        for (int i = 7; i >= 0; i--) begin
            repeat ($urandom_range(1, 3)) idle();
            if (i == 0) chk("gap_no_early_valid", 32'(bus0.dout_valid), 0);
            send_bit(w[i], i == 7);
        end
        idle();
        chk("gap_dout",  32'(bus0.dout), 32'h3C);
        chk("gap_valid", 32'(bus0.dout_valid), 1);
        idle();

        // Backpressure and overrun
        bus0.dout_ready = 1'b0;
        send_word(8'h3C);
        idle();
        chk("bp_first_dout",    32'(bus0.dout), 32'h3C);
        chk("bp_first_overrun", 32'(bus0.overrun), 0);
        send_word(8'hFF);
        idle();
        chk("bp_hold_dout",  32'(bus0.dout), 32'h3C);
        chk("bp_hold_valid", 32'(bus0.dout_valid), 1);
        chk("bp_overrun",    32'(bus0.overrun), 1);
        chk("bp_lsb_dout",   32'(bus1.dout), 32'h3C);
        bus0.dout_ready = 1'b1;
        @(negedge clk);
        bus0.dout_ready = 1'b0;
        chk("bp_drain_valid",  32'(bus0.dout_valid), 0);
        chk("bp_overrun_stick", 32'(bus0.overrun), 1);
        idle();
        chk("bp_overrun_stick2", 32'(bus0.overrun), 1);

        // Simultaneous handshake and completion
        do_reset();
        chk("rst_clears_overrun", 32'(bus0.overrun), 0);
        send_word(8'h11);
        idle();
        chk("sim_first_dout", 32'(bus0.dout), 32'h11);
        w = 8'h22;
        for (int i = 7; i >= 1; i--) send_bit(w[i], i == 7);
        chk("sim_hold_dout", 32'(bus0.dout), 32'h11);
        send_bit(w[0], 1'b0);
        bus0.dout_ready = 1'b1;
        idle();
        chk("sim_dout",    32'(bus0.dout), 32'h22);
        chk("sim_valid",   32'(bus0.dout_valid), 1);
        chk("sim_overrun", 32'(bus0.overrun), 0);
        chk("sim_lsb_dout", 32'(bus1.dout), 32'h44);
        idle();
        chk("sim_drain", 32'(bus0.dout_valid), 0);

        // Resync: 3 garbage bits, then a started 0x81
        send_bit(1'b1, 1'b1);
        send_bit(1'b1, 1'b0);
        send_bit(1'b0, 1'b0);
        chk("garbage_no_ferr", 32'(bus0.frame_err), 0);
        send_bit(1'b1, 1'b1);
        chk("pre_resync_ferr", 32'(bus0.frame_err), 0);
        send_bit(1'b0, 1'b0);
        chk("resync_ferr", 32'(bus0.frame_err), 1);
        send_bit(1'b0, 1'b0);
        chk("resync_ferr_pulse", 32'(bus0.frame_err), 0);
        for (int i = 0; i < 4; i++) send_bit(1'b0, 1'b0);
        chk("resync_no_early", 32'(bus0.dout_valid), 0);
        send_bit(1'b1, 1'b0);
        idle();
        chk("resync_dout",  32'(bus0.dout), 32'h81);
        chk("resync_valid", 32'(bus0.dout_valid), 1);
        chk("resync_lsb",   32'(bus1.dout), 32'h81);
        idle();

        // Reset mid-word discards the partial word
        for (int i = 0; i < 4; i++) send_bit(1'b1, i == 0);
        do_reset();
        chk("midword_rst_valid", 32'(bus0.dout_valid), 0);
        send_word(8'hC3);
        idle();
        chk("midword_rst_dout", 32'(bus0.dout), 32'hC3);
        chk("midword_rst_lsb",  32'(bus1.dout), 32'hC3);

        repeat (2) idle();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    // Remaining bits of 0xA5 (bit index 5 down to 0)
    function automatic logic w_a5(input int i);
        logic [7:0] v;
        v = 8'hA5;
        return v[i];
    endfunction

    initial begin
        #200000;
        $display("FAIL timeout: got no finish, expected finish");
        $display("%0d/%0d checks passed", n_pass, n_chk + 1);
        $fatal(1);
    end
endmodule

// File: doc/param_sipo_deser.md
Name: param_sipo_deser

Overview:
- Serial-in / parallel-out deserializer. It is the receive-side counterpart of the parameterized parallel-load shift register.
- Accepts one bit per qualified clock and assembles WIDTH-bit words.
- Presents each completed word on a registered valid/ready output port.
- Provides frame resync, a frame-error pulse, and a sticky overrun flag for words dropped under backpressure.

Parameters:
- WIDTH, 8, word width in bits; legal range WIDTH >= 2.
- MSB_FIRST, 1, 1: first received bit lands in dout[WIDTH-1]; 0: first bit lands in dout[0].

Ports:
- clk  input  1  single clock; all logic on posedge.
- rst  input  1  synchronous, active-high reset.
- sin_valid  input  1  sin_data/sin_start are sampled only when high.
- sin_data  input  1  serial data bit.
- sin_start  input  1  marks the current bit as bit 0 of a new word; qualified by sin_valid.
- dout  output  WIDTH  assembled word, registered.
- dout_valid  output  1  dout holds an unconsumed word.
- dout_ready  input  1  consumer accepts dout when dout_valid && dout_ready.
- frame_err  output  1  one-cycle pulse: sin_start arrived while a word was partially received.
- overrun  output  1  sticky; a completed word was dropped.

Behaviour:
- Reset: when rst=1 at posedge, the following are cleared:
  - dout=0, dout_valid=0, frame_err=0, overrun=0;
  - bit counter=0, shift register=0, FSM=IDLE.
  - rst has priority over every other input. Reset mid-word discards the partial word.
- FSM:
  - IDLE (count=0): a qualified bit (sin_valid=1) is shifted in, count becomes 1, and the FSM moves to SHIFT. sin_start in IDLE is accepted silently.
  - SHIFT (1 <= count <= WIDTH-1): each qualified bit is shifted in and count increments. On the WIDTH-th bit the word completes, count returns to 0 and the FSM goes to IDLE.
  - sin_valid=0: no state change; count and shift register hold.
- Resync: sin_valid=1 with sin_start=1 while in SHIFT:
  - the partial word is discarded;
  - the current bit becomes bit 0 of the new word and count=1;
  - frame_err=1 for exactly the next cycle.
- Bit placement:
  - MSB_FIRST=1: shift left, new bit into LSB. First bit ends in dout[WIDTH-1].
  - MSB_FIRST=0: shift right, new bit into MSB. First bit ends in dout[0].
- Completion latency: dout and dout_valid update at the same posedge that samples the final bit. dout_valid is visible in the following cycle, one cycle after the last bit is presented.
- Output handshake:
  - Transfer occurs when dout_valid && dout_ready at a posedge. dout_valid then clears unless a new word completes at that same edge.
  - While dout_valid=1 && dout_ready=0, dout must stay stable.
- Simultaneous completion and handshake (dout_valid=1, dout_ready=1, final bit at the same edge): dout loads the new word, dout_valid stays 1, overrun is unchanged.
- Overrun: word completes while dout_valid=1 && dout_ready=0:
  - the new word is dropped and dout is unchanged;
  - overrun is set to 1 and held until rst.
- Receive continues regardless of output state. The shifter never stalls; sin_valid has no backpressure.
- frame_err is never asserted for sin_start in IDLE or for sin_start coinciding with count=0.
- No combinational path from inputs to outputs.

Test Plan:
- Reset: rst=1 for 2 cycles with random sin_* inputs -> dout=0x00, dout_valid=0, frame_err=0, overrun=0. Immediately after, 8 bits of 0x5A (MSB first) -> dout=0x5A.
- Basic word, WIDTH=8, MSB_FIRST=1, dout_ready=1: sin_start on the first bit, bits 1,0,1,0,0,1,0,1 on consecutive cycles -> dout_valid=1 for exactly one cycle, starting the cycle after the 8th bit, dout=0xA5. With MSB_FIRST=0 the same bit sequence -> dout=0xA5 bit-reversed=0xA5 (palindrome). So also check bits of 0x01 (MSB-first order) -> MSB_FIRST=0 gives dout=0x80.
- Gapped input: send 0x3C with sin_valid low for 1-3 random cycles between bits -> dout=0x3C; dout_valid asserts only after the 8th qualified bit.
- Backpressure/overrun, dout_ready=0: send 0x3C then 0xFF -> dout stays 0x3C, dout_valid=1, overrun=1 after the 0xFF completes. Then dout_ready=1 for one cycle -> dout_valid=0, overrun remains 1.
- Simultaneous handshake: dout_valid=1 holding 0x11, dout_ready=1 exactly on the completion edge of 0x22 -> dout=0x22, dout_valid=1, overrun=0.
- Resync: 3 bits of garbage, then sin_start with 0x81 -> frame_err pulses once (one cycle), the next word out is 0x81, and the garbage bits never appear on dout.
